regfile_wb_arbiter: RTL and testbench

- Sequences the single register-file write port and tracks pending destination registers for the multi-cycle NPC core.
- Arbitrates writeback between the EXU (ALU results) and the LSU (load data).
- Keeps a 32-entry busy scoreboard and holds instruction issue on RAW/WAW hazards.
- Drives the register file's write enable, write address and write data from registered outputs.

---
 rtl/regfile_wb_arbiter_pkg.sv | 10 +
 rtl/regfile_wb_arbiter_scoreboard.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 74 +++++++
 tb/tb_regfile_wb_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, constants and grant encoding for the writeback arbiter.
package regfile_wb_arbiter_pkg;
  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam logic [XLEN-1:0] ZeroWord = '0;
  typedef logic [XLEN-1:0] reg_bus_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_EXU, GNT_LSU} gnt_e;
endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// rf_scoreboard: 32-entry busy vector with set/clear ports and three combinational lookups.
module rf_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rd,
  output logic                busy_rs1,
  output logic                busy_rs2,
  output logic                busy_rd,
  output logic [NUM_REGS-1:0] busy_vec
);
  logic [NUM_REGS-1:0] busy_q, busy_d, set_mask, clr_mask;
  always_comb begin
    set_mask = set_en ? NUM_REGS'(1) << set_idx : '0;
    clr_mask = clr_en ? NUM_REGS'(1) << clr_idx : '0;
    // set is applied after clear so a collision leaves the register busy
    busy_d = ((busy_q & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
    busy_rs1 = busy_q[rs1];
    busy_rs2 = busy_q[rs2];
    busy_rd = busy_q[rd];
    busy_vec = busy_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) busy_q <= '0;
    else begin
      assert (!(set_en && clr_en && set_idx == clr_idx && set_idx != '0));
      busy_q <= busy_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: EXU/LSU writeback arbitration with anti-starvation and RAW/WAW issue hold.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN     = regfile_wb_arbiter_pkg::XLEN,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  input  logic            issue_wen,
  output logic            issue_ready,
  input  logic            exu_valid,
  input  logic [4:0]      exu_rd,
  input  logic [XLEN-1:0] exu_data,
  output logic            exu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     busy_vec
);
  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);
  logic busy_rs1, busy_rs2, busy_rd, set_en;
  gnt_e gnt;
  logic [3:0] wait_q, wait_d;
  logic rf_wen_q, rf_wen_d;
  logic [4:0] rf_waddr_q, rf_waddr_d, gnt_rd;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d, gnt_data;
  rf_scoreboard u_sb (
    .clk(clk), .rst(rst),
    .set_en(set_en), .set_idx(issue_rd),
    .clr_en(rf_wen_q), .clr_idx(rf_waddr_q),
    .rs1(issue_rs1), .rs2(issue_rs2), .rd(issue_rd),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_rd(busy_rd),
    .busy_vec(busy_vec)
  );
  always_comb begin
    issue_ready = !rst && issue_valid && !busy_rs1 && !busy_rs2 && !(issue_wen && busy_rd);
    set_en = issue_ready && issue_wen;
    gnt = rst ? GNT_NONE
        : exu_valid && (!lsu_valid || wait_q == MaxWait) ? GNT_EXU
        : lsu_valid ? GNT_LSU : GNT_NONE;
    exu_ready = gnt == GNT_EXU;
    lsu_ready = gnt == GNT_LSU;
    gnt_rd = exu_ready ? exu_rd : lsu_rd;
    gnt_data = exu_ready ? exu_data : lsu_data;
    wait_d = (!exu_valid || exu_ready) ? 4'd0 : wait_q == MaxWait ? MaxWait : wait_q + 4'd1;
    rf_wen_d = gnt != GNT_NONE && gnt_rd != 5'd0;
    rf_waddr_d = gnt != GNT_NONE ? gnt_rd : rf_waddr_q;
    rf_wdata_d = gnt != GNT_NONE ? gnt_data : rf_wdata_q;
    rf_wen = rf_wen_q;
    rf_waddr = rf_waddr_q;
    rf_wdata = rf_wdata_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wait_q <= '0;
      rf_wen_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wait_q <= wait_d;
      rf_wen_q <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors with hand-computed expectations for the writeback arbiter.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic issue_valid = 0, issue_wen = 0;
  logic [4:0] issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0;
  logic exu_valid = 0, lsu_valid = 0;
  logic [4:0] exu_rd = 0, lsu_rd = 0;
  logic [63:0] exu_data = 0, lsu_data = 0;
  logic issue_ready, exu_ready, lsu_ready, rf_wen;
  logic [4:0] rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] busy_vec;
  int vectors = 0, miscompares = 0;
  regfile_wb_arbiter #(.XLEN(64), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_wen(issue_wen), .issue_ready(issue_ready),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d, input logic w);
    issue_valid = v; issue_rs1 = r1; issue_rs2 = r2; issue_rd = d; issue_wen = w;
  endtask
  initial begin
    issue_valid = 1; exu_valid = 1; lsu_valid = 1;
    #12;
    chk("rst_issue_ready", issue_ready, 0);
    chk("rst_exu_ready", exu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_wen", rf_wen, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    issue(0, 0, 0, 0, 0); exu_valid = 0; lsu_valid = 0;
    tick(); rst = 0;
    tick();
    issue(1, 0, 0, 5, 1); #1;
    chk("raw_issue_rd5", issue_ready, 1);
    tick();
    chk("raw_busy5", busy_vec, 32'h20);
    issue(1, 5, 0, 6, 1);
    exu_valid = 1; exu_rd = 5; exu_data = 64'h1234; #1;
    chk("raw_stall", issue_ready, 0);
    chk("raw_exu_gnt", exu_ready, 1);
    chk("raw_lsu_idle", lsu_ready, 0);
    tick(); exu_valid = 0; #1;
    chk("raw_wen", rf_wen, 1);
    chk("raw_waddr", rf_waddr, 5);
    chk("raw_wdata", rf_wdata, 64'h1234);
    chk("raw_stall_n1", issue_ready, 0);
    tick();
    chk("raw_busy_clr", busy_vec, 0);
    chk("raw_fire_n2", issue_ready, 1);
    tick(); issue(0, 0, 0, 0, 0); #1;
    chk("raw_busy6", busy_vec, 32'h40);
    chk("raw_no_wen", rf_wen, 0);
    lsu_valid = 1; lsu_rd = 6; lsu_data = 64'h66; #1;
    chk("clr6_lsu_gnt", lsu_ready, 1);
    tick(); lsu_valid = 0; #1;
    chk("clr6_waddr", rf_waddr, 6);
    tick();
    chk("clr6_busy", busy_vec, 0);
    exu_valid = 1; exu_rd = 1; exu_data = 64'hE; lsu_valid = 1; lsu_rd = 2; lsu_data = 64'hD;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("prio_exu", exu_ready, (k % 5 == 4));
      chk("prio_lsu", lsu_ready, (k % 5 != 4));
      if (k > 0) chk("prio_waddr", rf_waddr, ((k - 1) % 5 == 4) ? 5'd1 : 5'd2);
      tick();
    end
    tick(); tick(); exu_valid = 0; #1;
    chk("wait_drop_lsu", lsu_ready, 1);
    tick(); exu_valid = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("wait_clr_exu", exu_ready, (k == 4));
      tick();
    end
    exu_valid = 0; lsu_valid = 0;
    tick();
    issue(1, 0, 0, 0, 1); #1;
    chk("x0_issue", issue_ready, 1);
    tick(); issue(0, 0, 0, 0, 0);
    lsu_valid = 1; lsu_rd = 0; lsu_data = 64'hBAD; #1;
    chk("x0_busy", busy_vec, 0);
    chk("x0_lsu_gnt", lsu_ready, 1);
    tick(); lsu_valid = 0; #1;
    chk("x0_no_wen", rf_wen, 0);
    issue(1, 0, 0, 7, 1);
    tick();
    chk("waw_busy7", busy_vec, 32'h80);
    chk("waw_stall", issue_ready, 0);
    lsu_valid = 1; lsu_rd = 7; lsu_data = 64'h77; #1;
    chk("waw_lsu_gnt", lsu_ready, 1);
    tick(); lsu_valid = 0; #1;
    chk("waw_stall_n1", issue_ready, 0);
    chk("waw_waddr", rf_waddr, 7);
    tick();
    chk("waw_fire", issue_ready, 1);
    tick(); issue(0, 0, 0, 0, 0); #1;
    chk("waw_rebusy7", busy_vec, 32'h80);
    lsu_valid = 1; lsu_rd = 3; lsu_data = 64'hA3;
    tick(); lsu_rd = 4; lsu_data = 64'hB4; #1;
    chk("b2b_wen0", rf_wen, 1);
    chk("b2b_waddr0", rf_waddr, 3);
    chk("b2b_wdata0", rf_wdata, 64'hA3);
    tick(); lsu_valid = 0; #1;
    chk("b2b_wen1", rf_wen, 1);
    chk("b2b_waddr1", rf_waddr, 4);
    chk("b2b_wdata1", rf_wdata, 64'hB4);
    tick();
    chk("b2b_idle", rf_wen, 0);
    chk("b2b_busy7", busy_vec, 32'h80);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 64'h99;
    tick(); #2;
    chk("pre_rst_wen", rf_wen, 1);
    rst = 1; #1;
    chk("mid_rst_busy", busy_vec, 0);
    chk("mid_rst_wen", rf_wen, 0);
    chk("mid_rst_waddr", rf_waddr, 0);
    chk("mid_rst_wdata", rf_wdata, 0);
    chk("mid_rst_lsu", lsu_ready, 0);
    lsu_valid = 0;
    tick(); rst = 0;
    tick();
    chk("post_rst_busy", busy_vec, 0);
    chk("post_rst_wen", rf_wen, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
